// File: rtl/conv_filter_pipe_pkg.sv
// Shared constants and elaboration-time helpers for the convolution filter pipeline.
package conv_filter_pkg;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic int acc_w(input int dw, input int ntap);
    return 2 * dw + clog2(ntap + 1);
  endfunction

  function automatic int tree_d(input int ntap);
    return clog2(ntap + 1);
  endfunction

  // Number of live operands remaining after lvl halvings of n operands.
  function automatic int unsigned tree_cnt(input int unsigned n, input int unsigned lvl);
    return (n + (32'd1 << lvl) - 32'd1) >> lvl;
  endfunction

  function automatic longint sat_bound(input int dw, input bit hi);
    longint one;
    one = 1;
    if (hi) return (one <<< (dw - 1)) - 1;
    return -(one <<< (dw - 1));
  endfunction

endpackage

// File: rtl/conv_filter_pipe_if.sv
// Input-window / output-result handshake bundle for conv_filter_pipe.
interface conv_filter_pipe_if
  import conv_filter_pkg::*;
#(
  parameter int KSIZE  = 3,
  parameter int DATA_W = 16
) ();
  localparam int NTAP  = KSIZE * KSIZE;
  localparam int ACC_W = acc_w(DATA_W, NTAP);

  logic                     in_valid;
  logic                     in_ready;
  logic [NTAP*DATA_W-1:0]   in_data;
  logic [NTAP*DATA_W-1:0]   in_weight;
  logic [ACC_W-1:0]         in_bias;
  logic                     out_valid;
  logic                     out_ready;
  logic [DATA_W-1:0]        out_data;
  logic                     out_sat;

  modport master (
    output in_valid, in_data, in_weight, in_bias, out_ready,
    input  in_ready, out_valid, out_data, out_sat
  );

  modport slave (
    input  in_valid, in_data, in_weight, in_bias, out_ready,
    output in_ready, out_valid, out_data, out_sat
  );
endinterface

// File: rtl/conv_filter_pipe_adder_tree.sv
// Registered binary adder tree: clog2(N_OPS) levels, each stalled by i_adv.
module conv_adder_tree
  import conv_filter_pkg::*;
#(
  parameter int N_OPS = 10,
  parameter int W     = 36
) (
  input  logic                 i_clk,
  input  logic                 i_adv,
  input  logic [N_OPS*W-1:0]   i_ops,
  output logic signed [W-1:0]  o_sum
);
  localparam int          LEVELS = clog2(N_OPS);
  localparam int unsigned N2     = 2 * N_OPS;

  // Arrays are twice as wide as needed so pair indices never leave range.
  logic signed [W-1:0] w_src [LEVELS][N2];
  logic signed [W-1:0] r_lvl [LEVELS][N2];

  always_comb begin
    for (int unsigned i = 0; i < N_OPS; i++) w_src[0][i] = $signed(i_ops[i*W +: W]);
    for (int unsigned i = N_OPS; i < N2; i++) w_src[0][i] = '0;
    for (int unsigned l = 1; l < LEVELS; l++)
      for (int unsigned i = 0; i < N2; i++) w_src[l][i] = r_lvl[l-1][i];
  end

  // An odd trailing operand is carried through its level unchanged.
  always_ff @(posedge i_clk) begin
    if (i_adv) begin
      for (int unsigned l = 0; l < LEVELS; l++) begin
        for (int unsigned i = 0; i < N_OPS; i++) begin
          if (2*i + 1 < tree_cnt(N_OPS, l))
            r_lvl[l][i] <= w_src[l][2*i] + w_src[l][2*i+1];
          else if (2*i < tree_cnt(N_OPS, l))
            r_lvl[l][i] <= w_src[l][2*i];
          else
            r_lvl[l][i] <= '0;
        end
        for (int unsigned i = N_OPS; i < N2; i++) r_lvl[l][i] <= '0;
      end
    end
  end

  assign o_sum = r_lvl[LEVELS-1][0];
endmodule

// File: rtl/conv_filter_pipe.sv
// KSIZE x KSIZE fixed-point convolution: multiply, adder tree, scale/saturate.
// Optional macro CONV_FILTER_RELU_EN clamps negative results to zero.
module conv_filter_pipe
  import conv_filter_pkg::*;
#(
  parameter int KSIZE     = 3,
  parameter int DATA_W    = 16,
  parameter int FRAC_BITS = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  conv_filter_pipe_if.slave bus
);
  localparam int NTAP   = KSIZE * KSIZE;
  localparam int NOPS   = NTAP + 1;
  localparam int ACC_W  = acc_w(DATA_W, NTAP);
  localparam int TREE_D = tree_d(NTAP);
  localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(sat_bound(DATA_W, 1'b1));
  localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(sat_bound(DATA_W, 1'b0));

  logic                       w_adv;
  logic signed [DATA_W-1:0]   w_a [NTAP];
  logic signed [DATA_W-1:0]   w_b [NTAP];
  logic signed [2*DATA_W-1:0] w_p [NTAP];
  logic [NOPS*ACC_W-1:0]      r_ops;
  logic [TREE_D:0]            r_vld;
  logic signed [ACC_W-1:0]    w_sum;
  logic signed [ACC_W-1:0]    w_scaled;
  logic [DATA_W-1:0]          w_res;
  logic                       w_sat;
  logic                       r_out_valid;
  logic [DATA_W-1:0]          r_out_data;
  logic                       r_out_sat;

  assign w_adv        = !r_out_valid || bus.out_ready;
  assign bus.in_ready = w_adv;

  always_comb begin
    for (int unsigned t = 0; t < NTAP; t++) begin
      w_a[t] = bus.in_data[t*DATA_W +: DATA_W];
      w_b[t] = bus.in_weight[t*DATA_W +: DATA_W];
      w_p[t] = w_a[t] * w_b[t];
    end
  end

  always_ff @(posedge clk) begin
    if (w_adv) begin
      for (int unsigned t = 0; t < NTAP; t++)
        r_ops[t*ACC_W +: ACC_W] <= {{(ACC_W-2*DATA_W){w_p[t][2*DATA_W-1]}}, w_p[t]};
      r_ops[NTAP*ACC_W +: ACC_W] <= bus.in_bias;
    end
  end

  conv_adder_tree #(
    .N_OPS (NOPS),
    .W     (ACC_W)
  ) u_tree (
    .i_clk (clk),
    .i_adv (w_adv),
    .i_ops (r_ops),
    .o_sum (w_sum)
  );

  assign w_scaled = w_sum >>> FRAC_BITS;

  always_comb begin
    w_sat = 1'b0;
    w_res = w_scaled[DATA_W-1:0];
    if (w_scaled > SAT_HI) begin
      w_sat = 1'b1;
      w_res = SAT_HI[DATA_W-1:0];
    end else if (w_scaled < SAT_LO) begin
      w_sat = 1'b1;
      w_res = SAT_LO[DATA_W-1:0];
    end
`ifdef CONV_FILTER_RELU_EN
    if (w_res[DATA_W-1]) w_res = '0;
`else
    w_res = w_res;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld       <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sat   <= 1'b0;
    end else if (w_adv) begin
      r_vld       <= {r_vld[TREE_D-1:0], bus.in_valid};
      r_out_valid <= r_vld[TREE_D];
      r_out_data  <= w_res;
      r_out_sat   <= w_sat;
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_sat   = r_out_sat;
endmodule
